// File: rtl/program_loader_pkg.sv
// Shared definitions for the program-load engine: FSM encoding, word geometry
// and the default halt instruction.
// Imported by program_loader; no logic of its own.
package loader_pkg;

   // Loader FSM encoding (2 bits).
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

   // UART bytes assembled into one instruction word.
   localparam int BYTES_PER_WORD = 4;

   // Instruction that terminates a program image.
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   // True when the byte counter points at the last byte of a word.
   function automatic logic is_last_byte(input logic [1:0] cnt);
      return cnt == 2'(BYTES_PER_WORD - 1);
   endfunction

endpackage

// File: rtl/program_loader.sv
// Purpose : assemble UART bytes MSB-first into words and preload them into program memory.
// Latency : preload strobe in the cycle after the 4th byte is sampled; done/overflow one cycle later.
// Backpressure: none; accepts one byte per cycle, including the byte that lands on a write cycle.
//
// Ports
//   i_clk, i_rst (async, active-low)
//   i_start                   : pulse, begins a load at address 0 (from IDLE or DONE only)
//   i_rx_data / i_rx_done     : UART byte and its one-cycle strobe
//   o_preload_flag            : one-cycle write strobe to program memory
//   o_preload_address/_instruction : write address / assembled word, held between writes
//   o_loading                 : high while receiving or writing (pipeline held off)
//   o_load_done, o_overflow   : completion levels, cleared by the next i_start
module program_loader
   import loader_pkg::*;
#(
   parameter int              LEN               = 32,
   parameter int              BYTE_LEN          = 8,
   parameter int              RAM_DEPTH_PROGRAM = 2048,
   parameter logic [LEN-1:0]  HALT_WORD         = LEN'(DEFAULT_HALT_WORD)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [BYTE_LEN-1:0] i_rx_data,
   input  logic                i_rx_done,
   output logic                o_preload_flag,
   output logic [LEN-1:0]      o_preload_address,
   output logic [LEN-1:0]      o_preload_instruction,
   output logic                o_loading,
   output logic                o_load_done,
   output logic                o_overflow
);

   localparam logic [LEN-1:0] LAST_ADDR = LEN'(RAM_DEPTH_PROGRAM - 1);
   localparam logic [LEN-1:0] ADDR_ONE  = LEN'(1);

   loader_state_e  state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [LEN-1:0] word_q, word_d;
   logic [LEN-1:0] addr_q, addr_d;

   logic           flag_d;
   logic [LEN-1:0] paddr_d;
   logic [LEN-1:0] instr_d;
   logic           loading_d;
   logic           done_d;
   logic           ovf_d;

   // Incoming byte appended at the LSB end; the oldest byte falls off the top.
   logic [LEN-1:0] word_shifted;
   assign word_shifted = {word_q[LEN-BYTE_LEN-1:0], i_rx_data};

   // ------------------------------------------------------------------
   // State register and all registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q               <= ST_IDLE;
         cnt_q                 <= '0;
         word_q                <= '0;
         addr_q                <= '0;
         o_preload_flag        <= 1'b0;
         o_preload_address     <= '0;
         o_preload_instruction <= '0;
         o_loading             <= 1'b0;
         o_load_done           <= 1'b0;
         o_overflow            <= 1'b0;
      end else begin
         state_q               <= state_d;
         cnt_q                 <= cnt_d;
         word_q                <= word_d;
         addr_q                <= addr_d;
         o_preload_flag        <= flag_d;
         o_preload_address     <= paddr_d;
         o_preload_instruction <= instr_d;
         o_loading             <= loading_d;
         o_load_done           <= done_d;
         o_overflow            <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      addr_d    = addr_q;
      flag_d    = 1'b0;
      paddr_d   = o_preload_address;
      instr_d   = o_preload_instruction;
      ovf_d     = o_overflow;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A byte arriving with the start pulse is dropped on purpose:
            // the counter is being cleared in the same cycle.
            if (i_start) begin
               state_d = ST_RECV;
               addr_d  = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end

         ST_RECV: begin
            if (i_rx_done) begin
               word_d = word_shifted;
               cnt_d  = cnt_q + 2'd1;
               if (is_last_byte(cnt_q)) begin
                  // Present the complete word, including this byte, next cycle.
                  state_d = ST_WRITE;
                  flag_d  = 1'b1;
                  paddr_d = addr_q;
                  instr_d = word_shifted;
               end
            end
         end

         ST_WRITE: begin
            // word_q still holds the word being written this cycle.
            if (word_q == HALT_WORD) begin
               state_d = ST_DONE;
            end else if (addr_q == LAST_ADDR) begin
               state_d = ST_DONE;
               ovf_d   = 1'b1;
            end else begin
               state_d = ST_RECV;
               addr_d  = addr_q + ADDR_ONE;
               // Counter wrapped to 0 on entry, so this becomes byte 0.
               if (i_rx_done) begin
                  word_d = word_shifted;
                  cnt_d  = cnt_q + 2'd1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      loading_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
      done_d    = (state_d == ST_DONE);
   end

endmodule

// File: tb/tb_program_loader.sv
// Purpose : scoreboard bench for program_loader against a byte-stream reference model.
// Latency : expected writes queued when the 4th byte is issued; popped when the strobe appears.
// Backpressure: none; stimulus drives one input set per cycle.
module tb_program_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_done = 1'b0;
   logic        o_preload_flag;
   logic [31:0] o_preload_address;
   logic [31:0] o_preload_instruction;
   logic        o_loading;
   logic        o_load_done;
   logic        o_overflow;

   program_loader #(
      .LEN               (32),
      .BYTE_LEN          (8),
      .RAM_DEPTH_PROGRAM (DEPTH),
      .HALT_WORD         (HALT)
   ) dut (
      .i_clk                 (i_clk),
      .i_rst                 (i_rst),
      .i_start               (i_start),
      .i_rx_data             (i_rx_data),
      .i_rx_done             (i_rx_done),
      .o_preload_flag        (o_preload_flag),
      .o_preload_address     (o_preload_address),
      .o_preload_instruction (o_preload_instruction),
      .o_loading             (o_loading),
      .o_load_done           (o_load_done),
      .o_overflow            (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   // Reference model: a load session viewed as a stream of accepted bytes.
   typedef enum {M_IDLE, M_LOAD, M_DONE} mph_e;
   mph_e        m_ph = M_IDLE;
   int          m_addr = 0;
   int          m_nb = 0;
   logic [31:0] m_word = '0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_last_addr = '0;
   logic [31:0] m_last_data = '0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   task automatic model_cycle(input bit st, input bit rv, input logic [7:0] d);
      if (st && m_ph != M_LOAD) begin
         m_ph  = M_LOAD;
         m_addr = 0;
         m_nb  = 0;
         m_ovf = 1'b0;
         return;
      end
      if (rv && m_ph == M_LOAD) begin
         m_word = (m_word << 8) | 32'(d);
         m_nb++;
         if (m_nb == 4) begin
            m_nb = 0;
            exp_q.push_back('{addr: 32'(m_addr), data: m_word});
            m_last_addr = 32'(m_addr);
            m_last_data = m_word;
            if (m_word == HALT) begin
               m_ph = M_DONE;
            end else if (m_addr == DEPTH - 1) begin
               m_ph  = M_DONE;
               m_ovf = 1'b1;
            end else begin
               m_addr++;
            end
         end
      end
   endtask

   task automatic drive(input bit st, input bit rv, input logic [7:0] d);
      @(negedge i_clk);
      i_start   = st;
      i_rx_done = rv;
      i_rx_data = d;
      @(posedge i_clk);
      model_cycle(st, rv, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int i = 3; i >= 0; i--) begin
         drive(1'b0, 1'b1, w[8*i +: 8]);
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic check_levels(input string tag);
      @(negedge i_clk);
      chk({tag, "_flag"},    32'(o_preload_flag), 32'd0);
      chk({tag, "_loading"}, 32'(o_loading),      32'(m_ph == M_LOAD));
      chk({tag, "_done"},    32'(o_load_done),    32'(m_ph == M_DONE));
      chk({tag, "_ovf"},     32'(o_overflow),     32'(m_ovf));
      chk({tag, "_addr"},    o_preload_address,     m_last_addr);
      chk({tag, "_instr"},   o_preload_instruction, m_last_data);
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once.
   task automatic do_reset(input string tag);
      @(negedge i_clk);
      i_start   = 1'b0;
      i_rx_done = 1'b0;
      #2 i_rst = 1'b0;
      #1;
      chk({tag, "_flag"},    32'(o_preload_flag), 32'd0);
      chk({tag, "_addr"},    o_preload_address,     32'd0);
      chk({tag, "_instr"},   o_preload_instruction, 32'd0);
      chk({tag, "_loading"}, 32'(o_loading),   32'd0);
      chk({tag, "_done"},    32'(o_load_done), 32'd0);
      chk({tag, "_ovf"},     32'(o_overflow),  32'd0);
      m_ph = M_IDLE; m_nb = 0; m_addr = 0; m_ovf = 1'b0;
      m_last_addr = '0; m_last_data = '0;
      @(negedge i_clk);
      i_rst = 1'b1;
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge i_clk) begin
      if (i_rst && o_preload_flag) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                     o_preload_address, o_preload_instruction);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_addr", o_preload_address,     e.addr);
            chk("write_data", o_preload_instruction, e.data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      int          nw;
      bit          st;

      // Reset state (reset asserted from time 0).
      #3;
      chk("rst_flag",    32'(o_preload_flag), 32'd0);
      chk("rst_loading", 32'(o_loading),      32'd0);
      chk("rst_done",    32'(o_load_done),    32'd0);
      chk("rst_ovf",     32'(o_overflow),     32'd0);
      chk("rst_addr",    o_preload_address,     32'd0);
      chk("rst_instr",   o_preload_instruction, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b1;

      // Bytes in IDLE are ignored.
      send_word(32'hDEAD_BEEF, 0);
      idle(2);
      check_levels("idle_bytes");

      // Single word, then a halt-terminated program.
      drive(1'b1, 1'b0, 8'h00);
      send_word(32'h2001_0005, 1);
      idle(2);
      check_levels("single");
      send_word(32'h0000_0001, 0);
      send_word(HALT, 0);
      idle(2);
      check_levels("halt");

      // Bytes in DONE are ignored; start mid-word is ignored.
      send_word(32'h1234_5678, 0);
      idle(2);
      check_levels("done_bytes");
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'hA1);
      drive(1'b0, 1'b1, 8'hA2);
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'hA3);
      drive(1'b0, 1'b1, 8'hA4);
      idle(2);
      check_levels("mid_start");

      // Back-to-back bytes across a write cycle.
      idle(2);
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 8'(i));
      idle(2);
      check_levels("b2b");

      // Overflow: five non-halt words into a 4-deep memory.
      drive(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) send_word(32'h1000_0000 + 32'(k), 0);
      idle(2);
      check_levels("overflow");

      // Reset mid-load, then start with a same-cycle byte (dropped).
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h55);
      drive(1'b0, 1'b1, 8'h66);
      do_reset("midrst");
      drive(1'b1, 1'b1, 8'h99);
      send_word(32'hCAFE_F00D, 0);
      idle(2);
      check_levels("after_rst");

      // Randomized sessions.
      for (int s = 0; s < 40; s++) begin
         idle(2);
         drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
         nw = $urandom_range(1, 6);
         for (int k = 0; k < nw; k++) begin
            w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
            for (int b = 3; b >= 0; b--) begin
               st = (m_ph == M_LOAD) && ($urandom_range(0, 7) == 0);
               drive(st, 1'b1, w[8*b +: 8]);
               for (int g = $urandom_range(0, 2); g > 0; g--) begin
                  st = (m_ph == M_LOAD) && ($urandom_range(0, 7) == 0);
                  drive(st, 1'b0, 8'h00);
               end
            end
         end
         idle(2);
         check_levels("rand");
      end

      idle(3);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
